pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the 5-stage pipeline. It drives the PC register's addr_in
//   every cycle, choosing among the following sources:
//     - sequential fetch
//     - branch redirect
//     - jump redirect
//     - exception vector
//     - hold (stall)
//   Redirects that arrive during a stall are buffered and replayed once the stall
//   releases. The block also generates IF/ID flush bubbles after every applied redirect.
// PARAMETERS
//   PC_INIT       32'h0000_0034  value driven on next_pc_o while Reset is asserted
//   EXC_VEC       32'h0000_4180  exception handler entry address
//   FLUSH_CYCLES  1              bubbles inserted after an applied redirect (1..7)
// PORTS
//   clk          in   1   clock; all registers update on the falling edge, same as the PC register
//   Reset        in   1   asynchronous, active-low reset (0 = reset)
//   pc_cur_i     in   32  current PC (PC register addr_out)
//   stall_i      in   1   hazard unit stall request
//   br_taken_i   in   1   branch resolved taken (ID stage)
//   br_target_i  in   32  branch target
//   jmp_i        in   1   jump/jr in ID
//   jmp_target_i in   32  jump target
//   exc_i        in   1   exception raised (any stage)
//   next_pc_o    out  32  to PC addr_in
//   flush_if_o   out  1   squash IF/ID register contents
//   pend_valid_o out  1   a buffered redirect is waiting
//   align_err_o  out  1   one-cycle pulse: misaligned target was accepted
//   state_o      out  2   00 RUN, 01 HOLD, 10 FLUSH
// BEHAVIOUR
//   Reset low:
//     - async clear: state=RUN, pend_valid=0, pend_tgt=0, flush count=0, align_err=0
//     - next_pc_o=PC_INIT; flush_if_o=0
//   Redirect priority (combinational, same cycle): exc_i > br_taken_i > jmp_i > pending > stall > seq
//     - exc_i: next_pc_o=EXC_VEC even when stall_i=1; clears any pending; enters FLUSH
//     - br/jmp with stall_i=0: next_pc_o=target; enters FLUSH
//     - br/jmp with stall_i=1: next_pc_o=pc_cur_i; target latched into pend_tgt, pend_valid=1,
//       state HOLD. A later br/jmp in HOLD overwrites pend_tgt (last resolved wins).
//     - HOLD with stall_i=0: next_pc_o=pend_tgt; pend_valid clears on that edge; enters FLUSH
//     - stall_i=1 with no redirect: next_pc_o=pc_cur_i (PC holds)
//     - otherwise: next_pc_o=pc_cur_i+4, modulo 2^32 (32'hFFFF_FFFC -> 0)
//   Alignment: targets with [1:0]!=0 are used with [1:0] forced to 00;
//     align_err_o pulses for one cycle on the edge at which the target is accepted.
//   FLUSH:
//     - flush_if_o=1 for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge
//     - counter loads FLUSH_CYCLES on entry
//     - a new redirect during FLUSH is applied and reloads the counter
//     - stall_i during FLUSH does not pause the counter
//     - returns to RUN when the count reaches 0 (or to HOLD if pend_valid)
//   Latency: redirect -> next_pc_o is 0 cycles (combinational); PC updates on the next falling edge.
//   Reset mid-FLUSH or mid-HOLD: pending target is discarded; restart at PC_INIT.
// TESTING
//   1 Reset low, then release; pc_cur follows -> next_pc_o 0x34, 0x38, 0x3C; flush_if_o=0
//   2 br_taken_i=1, br_target_i=0x100 at pc 0x40 -> next_pc_o=0x100;
//     flush_if_o=1 for 1 cycle; state 00->10->00
//   3 stall_i=1 for 3 cycles with jmp_target_i=0x200 in cycle 1 ->
//     next_pc_o=pc_cur_i, pend_valid_o=1; on release next_pc_o=0x200, then flush
//   4 exc_i=1 together with br_taken_i=1 and stall_i=1 -> next_pc_o=EXC_VEC (0x4180);
//     pend_valid_o=0
//   5 pc_cur_i=0xFFFF_FFFC, no events -> next_pc_o=0; br_target_i=0x102 -> 0x100 with align_err_o pulse
//   6 Reset asserted while in HOLD with pend_valid_o=1 -> outputs cleared asynchronously;
//     after release, fetch restarts at 0x34

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: pipeline-side redirect requests in, next-PC selection and status out.
interface pc_sequencer_if;
  logic [31:0] pc_cur_i;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        exc_i;
  logic [31:0] next_pc_o;
  logic        flush_if_o;
  logic        pend_valid_o;
  logic        align_err_o;
  logic [1:0]  state_o;
  modport master (
    output pc_cur_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, exc_i,
    input  next_pc_o, flush_if_o, pend_valid_o, align_err_o, state_o
  );
  modport slave (
    input  pc_cur_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, exc_i,
    output next_pc_o, flush_if_o, pend_valid_o, align_err_o, state_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with stall-buffered redirects and IF/ID flush bubbles.
// Registers update on the falling clock edge, matching the PC register they feed.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT      = 32'h0000_0034,
  parameter logic [31:0] EXC_VEC      = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  localparam logic [1:0] RUN = 2'b00, HOLD = 2'b01, FLUSH = 2'b10;
  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);
  logic [1:0]  state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        align_err_q, align_err_d;
  logic        new_tgt, apply;
  logic [31:0] raw_tgt, tgt, redir_pc;
  always_ff @(negedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= RUN;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
      cnt_q        <= '0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      cnt_q        <= cnt_d;
      align_err_q  <= align_err_d;
    end
  end
  // A redirect is applied now unless it is a br/jmp (or replay) blocked by a stall.
  always_comb begin
    new_tgt      = bus.br_taken_i | bus.jmp_i;
    raw_tgt      = bus.br_taken_i ? bus.br_target_i : bus.jmp_target_i;
    tgt          = {raw_tgt[31:2], 2'b00};
    apply        = bus.exc_i | (!bus.stall_i & (new_tgt | pend_valid_q));
    pend_valid_d = !bus.exc_i & bus.stall_i & (new_tgt | pend_valid_q);
    pend_tgt_d   = bus.exc_i ? '0 : (bus.stall_i & new_tgt) ? tgt : pend_tgt_q;
    align_err_d  = !bus.exc_i & new_tgt & (|raw_tgt[1:0]);
    cnt_d        = apply ? FLUSH_LD : (state_q == FLUSH && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    state_d      = apply ? FLUSH : (state_q == FLUSH && cnt_q > 3'd1) ? FLUSH :
                   pend_valid_d ? HOLD : RUN;
  end
  always_comb begin
    redir_pc         = bus.exc_i ? EXC_VEC : new_tgt ? tgt : pend_tgt_q;
    bus.next_pc_o    = !Reset ? PC_INIT : apply ? redir_pc :
                       bus.stall_i ? bus.pc_cur_i : bus.pc_cur_i + 32'd4;
    bus.flush_if_o   = state_q == FLUSH;
    bus.pend_valid_o = pend_valid_q;
    bus.align_err_o  = align_err_q;
    bus.state_o      = state_q;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall_i = 0; bus.br_taken_i = 0; bus.jmp_i = 0; bus.exc_i = 0;
  endtask
  task automatic test_reset();
    idle();
    bus.pc_cur_i = 32'h0; bus.br_target_i = 32'h0; bus.jmp_target_i = 32'h0;
    #1;
    checks++; if (bus.next_pc_o !== 32'h34) begin errors++; $display("FAIL reset_pc: got %h exp %h", bus.next_pc_o, 32'h34); end
    checks++; if (bus.flush_if_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", bus.flush_if_o); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL reset_state: got %b exp 00", bus.state_o); end
    checks++; if (bus.pend_valid_o !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b exp 0", bus.pend_valid_o); end
    tick();
    Reset = 1; bus.pc_cur_i = 32'h34; #1;
    checks++; if (bus.next_pc_o !== 32'h38) begin errors++; $display("FAIL seq_38: got %h exp %h", bus.next_pc_o, 32'h38); end
    tick();
    bus.pc_cur_i = 32'h38; #1;
    checks++; if (bus.next_pc_o !== 32'h3C) begin errors++; $display("FAIL seq_3c: got %h exp %h", bus.next_pc_o, 32'h3C); end
    checks++; if (bus.flush_if_o !== 1'b0) begin errors++; $display("FAIL seq_flush: got %b exp 0", bus.flush_if_o); end
  endtask
  task automatic test_branch();
    tick();
    bus.pc_cur_i = 32'h40; bus.br_taken_i = 1; bus.br_target_i = 32'h100; #1;
    checks++; if (bus.next_pc_o !== 32'h100) begin errors++; $display("FAIL br_pc: got %h exp %h", bus.next_pc_o, 32'h100); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL br_state0: got %b exp 00", bus.state_o); end
    tick();
    idle(); bus.pc_cur_i = 32'h100; #1;
    checks++; if (bus.flush_if_o !== 1'b1) begin errors++; $display("FAIL br_flush: got %b exp 1", bus.flush_if_o); end
    checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL br_state1: got %b exp 10", bus.state_o); end
    checks++; if (bus.next_pc_o !== 32'h104) begin errors++; $display("FAIL br_seq: got %h exp %h", bus.next_pc_o, 32'h104); end
    tick();
    checks++; if (bus.flush_if_o !== 1'b0) begin errors++; $display("FAIL br_unflush: got %b exp 0", bus.flush_if_o); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL br_state2: got %b exp 00", bus.state_o); end
  endtask
  task automatic test_stall_jump();
    bus.pc_cur_i = 32'h104; bus.stall_i = 1; bus.jmp_i = 1; bus.jmp_target_i = 32'h200; #1;
    checks++; if (bus.next_pc_o !== 32'h104) begin errors++; $display("FAIL hold_pc0: got %h exp %h", bus.next_pc_o, 32'h104); end
    tick();
    bus.jmp_i = 0; #1;
    checks++; if (bus.pend_valid_o !== 1'b1) begin errors++; $display("FAIL hold_pend: got %b exp 1", bus.pend_valid_o); end
    checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL hold_state: got %b exp 01", bus.state_o); end
    checks++; if (bus.next_pc_o !== 32'h104) begin errors++; $display("FAIL hold_pc1: got %h exp %h", bus.next_pc_o, 32'h104); end
    tick();
    tick();
    bus.stall_i = 0; #1;
    checks++; if (bus.next_pc_o !== 32'h200) begin errors++; $display("FAIL replay_pc: got %h exp %h", bus.next_pc_o, 32'h200); end
    tick();
    bus.pc_cur_i = 32'h200; #1;
    checks++; if (bus.pend_valid_o !== 1'b0) begin errors++; $display("FAIL replay_pend: got %b exp 0", bus.pend_valid_o); end
    checks++; if (bus.flush_if_o !== 1'b1) begin errors++; $display("FAIL replay_flush: got %b exp 1", bus.flush_if_o); end
    tick();
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL replay_run: got %b exp 00", bus.state_o); end
  endtask
  task automatic test_exception();
    bus.stall_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h300;
    tick();
    bus.exc_i = 1; bus.br_target_i = 32'h500; #1;
    checks++; if (bus.next_pc_o !== 32'h4180) begin errors++; $display("FAIL exc_pc: got %h exp %h", bus.next_pc_o, 32'h4180); end
    tick();
    idle();
    checks++; if (bus.pend_valid_o !== 1'b0) begin errors++; $display("FAIL exc_pend: got %b exp 0", bus.pend_valid_o); end
    checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL exc_state: got %b exp 10", bus.state_o); end
    tick();
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL exc_run: got %b exp 00", bus.state_o); end
  endtask
  task automatic test_wrap_align();
    bus.pc_cur_i = 32'hFFFF_FFFC; #1;
    checks++; if (bus.next_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp %h", bus.next_pc_o, 32'h0); end
    bus.br_taken_i = 1; bus.br_target_i = 32'h102; #1;
    checks++; if (bus.next_pc_o !== 32'h100) begin errors++; $display("FAIL align_pc: got %h exp %h", bus.next_pc_o, 32'h100); end
    checks++; if (bus.align_err_o !== 1'b0) begin errors++; $display("FAIL align_pre: got %b exp 0", bus.align_err_o); end
    tick();
    idle();
    checks++; if (bus.align_err_o !== 1'b1) begin errors++; $display("FAIL align_pulse: got %b exp 1", bus.align_err_o); end
    tick();
    checks++; if (bus.align_err_o !== 1'b0) begin errors++; $display("FAIL align_end: got %b exp 0", bus.align_err_o); end
  endtask
  task automatic test_back_to_back();
    bus.pc_cur_i = 32'h104; bus.br_taken_i = 1; bus.br_target_i = 32'h700;
    tick();
    bus.br_taken_i = 0; bus.jmp_i = 1; bus.jmp_target_i = 32'h800; #1;
    checks++; if (bus.next_pc_o !== 32'h800) begin errors++; $display("FAIL b2b_pc: got %h exp %h", bus.next_pc_o, 32'h800); end
    tick();
    idle();
    checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL b2b_reload: got %b exp 10", bus.state_o); end
    tick();
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL b2b_run: got %b exp 00", bus.state_o); end
  endtask
  task automatic test_reset_mid_hold();
    bus.stall_i = 1; bus.jmp_i = 1; bus.jmp_target_i = 32'h600;
    tick();
    checks++; if (bus.pend_valid_o !== 1'b1) begin errors++; $display("FAIL rh_pend: got %b exp 1", bus.pend_valid_o); end
    #2 Reset = 0; #1;
    checks++; if (bus.pend_valid_o !== 1'b0) begin errors++; $display("FAIL rh_clr_pend: got %b exp 0", bus.pend_valid_o); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL rh_clr_state: got %b exp 00", bus.state_o); end
    checks++; if (bus.next_pc_o !== 32'h34) begin errors++; $display("FAIL rh_pc: got %h exp %h", bus.next_pc_o, 32'h34); end
    tick();
    Reset = 1; idle(); bus.pc_cur_i = 32'h34; #1;
    checks++; if (bus.next_pc_o !== 32'h38) begin errors++; $display("FAIL rh_restart: got %h exp %h", bus.next_pc_o, 32'h38); end
    tick();
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL rh_state: got %b exp 00", bus.state_o); end
  endtask
  initial begin
    test_reset();
    test_branch();
    test_stall_jump();
    test_exception();
    test_wrap_align();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
